// File: rtl/chess_pkg.sv
// Shared definitions for the chess-engine move-generation sequencer:
// engine command opcodes, engine response bit positions and the FSM states.
package chess_pkg;

    localparam logic [7:0] OP_ENABLE_ALL  = 8'h60;
    localparam logic [7:0] OP_SET_ENABLE  = 8'h80;
    localparam logic [7:0] OP_FIND_VICTIM = 8'hC0;
    localparam logic [7:0] OP_FIND_AGGR   = 8'hE0;

    localparam int SIDE_BIT        = 4;
    localparam int ENG_ILLEGAL_BIT = 7;
    localparam int ENG_NONE_BIT    = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EN_ALL,
        S_V_RESTORE,
        S_V_FIND,
        S_V_SAMPLE,
        S_A_EN_ALL,
        S_A_FIND,
        S_A_SAMPLE,
        S_EMIT,
        S_A_DIS,
        S_DONE
    } state_t;

    // FIND opcodes carry the side to move in bit 4.
    function automatic logic [7:0] with_side(input logic [7:0] op, input logic side);
        logic [7:0] r;
        r = op;
        r[SIDE_BIT] = side;
        return r;
    endfunction

endpackage

// File: rtl/movegen_seq_if.sv
// Move stream handshake: the sequencer is the master, the move consumer the slave.
interface movegen_seq_if;

    logic       mv_valid;
    logic       mv_ready;
    logic [5:0] mv_from;
    logic [5:0] mv_to;

    modport master (output mv_valid, output mv_from, output mv_to, input mv_ready);
    modport slave  (input mv_valid, input mv_from, input mv_to, output mv_ready);

endinterface

// File: rtl/sq_mask_enc.sv
// Lowest-set-bit encoder over a 64-square mask; the caller clears the bit.
module sq_mask_enc (
    input  logic [63:0] mask,
    output logic [5:0]  idx,
    output logic        any
);

    // Scan from the top so the lowest set square is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (mask[i]) idx = 6'(i);
        end
    end

    assign any = |mask;

endmodule

// File: rtl/movegen_seq.sv
// Move-generation sequencer: drives the chess engine one command per cycle,
// walks victims and their aggressors, and streams the resulting moves.
module movegen_seq
    import chess_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             side,
    input  logic             abort,
    output logic [7:0]       cmd_addr,
    output logic [5:0]       cmd_data,
    input  logic [7:0]       eng_data,
    movegen_seq_if.master    mv,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] move_count
);

    state_t      state;
    state_t      state_nxt;
    logic        side_q;
    logic [63:0] done_mask;
    logic [63:0] work_mask;
    logic [5:0]  victim;
    logic [5:0]  from_sq;
    logic        first_sample;
    logic [5:0]  work_idx;
    logic        work_any;
    logic        mv_valid;

    sq_mask_enc u_enc (
        .mask (work_mask),
        .idx  (work_idx),
        .any  (work_any)
    );

    // State register plus the run bookkeeping each state owns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            side_q     <= 1'b0;
            done_mask  <= '0;
            illegal    <= 1'b0;
            move_count <= '0;
        end else begin
            state <= state_nxt;
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            side_q       <= side;
                            done_mask    <= '0;
                            illegal      <= 1'b0;
                            move_count   <= '0;
                            first_sample <= 1'b1;
                        end
                    end
                    S_EN_ALL: work_mask <= done_mask;
                    S_V_RESTORE: begin
                        if (work_any) work_mask[work_idx] <= 1'b0;
                    end
                    S_V_SAMPLE: begin
                        first_sample <= 1'b0;
                        if (first_sample && eng_data[ENG_ILLEGAL_BIT]) begin
                            illegal <= 1'b1;
                        end else if (!eng_data[ENG_NONE_BIT]) begin
                            victim <= eng_data[5:0];
                        end
                    end
                    S_A_SAMPLE: begin
                        if (eng_data[ENG_NONE_BIT]) done_mask[victim] <= 1'b1;
                        else                        from_sq <= eng_data[5:0];
                    end
                    S_EMIT: begin
                        if (mv.mv_ready && (move_count != '1)) move_count <= move_count + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Next state, engine command and move-stream outputs; abort overrides all.
    always_comb begin
        state_nxt = state;
        cmd_addr  = with_side(OP_FIND_VICTIM, side_q);
        cmd_data  = '0;
        mv_valid  = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_EN_ALL;
            end
            S_EN_ALL: begin
                cmd_addr  = OP_ENABLE_ALL;
                state_nxt = S_V_RESTORE;
            end
            S_V_RESTORE: begin
                if (work_any) cmd_addr = OP_SET_ENABLE | {2'b00, work_idx};
                else          state_nxt = S_V_FIND;
            end
            S_V_FIND: state_nxt = S_V_SAMPLE;
            S_V_SAMPLE: begin
                if (first_sample && eng_data[ENG_ILLEGAL_BIT]) state_nxt = S_DONE;
                else if (eng_data[ENG_NONE_BIT])              state_nxt = S_DONE;
                else                                          state_nxt = S_A_EN_ALL;
            end
            S_A_EN_ALL: begin
                cmd_addr  = OP_ENABLE_ALL;
                state_nxt = S_A_FIND;
            end
            S_A_FIND: begin
                cmd_addr  = with_side(OP_FIND_AGGR, side_q);
                cmd_data  = victim;
                state_nxt = S_A_SAMPLE;
            end
            S_A_SAMPLE: begin
                cmd_addr  = with_side(OP_FIND_AGGR, side_q);
                cmd_data  = victim;
                state_nxt = eng_data[ENG_NONE_BIT] ? S_EN_ALL : S_EMIT;
            end
            S_EMIT: begin
                cmd_addr = with_side(OP_FIND_AGGR, side_q);
                cmd_data = victim;
                mv_valid = 1'b1;
                if (mv.mv_ready) state_nxt = S_A_DIS;
            end
            S_A_DIS: begin
                cmd_addr  = OP_SET_ENABLE | {2'b00, from_sq};
                state_nxt = S_A_FIND;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            mv_valid  = 1'b0;
            done      = 1'b0;
        end
    end

    assign busy        = (state != S_IDLE);
    assign mv.mv_valid = mv_valid;
    assign mv.mv_from  = from_sq;
    assign mv.mv_to    = victim;

endmodule
